// File: rtl/bc_dcpl.sv
// bc_dcpl: decoupled broadcast. Each accepted din word is written into SIZE
// independent per-channel FIFOs (DEPTH entries each). The input stalls only
// when some channel's FIFO is full. All outputs come from registered state.
// Optional feature macro: BC_DCPL_LEVEL_EN adds the dout_level occupancy port.
module bc_dcpl #(
    parameter int SIZE  = 2,
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              din_valid,
    input  logic [WIDTH-1:0]                  din_data,
    output logic                              din_ready,
    output logic [SIZE-1:0]                   dout_valid,
    output logic [WIDTH*SIZE-1:0]             dout_data,
    input  logic [SIZE-1:0]                   dout_ready
`ifdef BC_DCPL_LEVEL_EN
    ,
    output logic [SIZE*($clog2(DEPTH)+1)-1:0] dout_level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem    [SIZE][DEPTH];
    logic [AW-1:0]    rd_ptr [SIZE];
    logic [AW-1:0]    wr_ptr [SIZE];
    logic [CW-1:0]    count  [SIZE];
    logic [CW-1:0]    cnt_nxt[SIZE];
    logic             push;
    logic [SIZE-1:0]  pop;
    logic             rdy_nxt;

    assign push = din_valid & din_ready;

    // Per-channel pop qualification, next occupancy and next-cycle din_ready.
    always_comb begin
        pop     = '0;
        rdy_nxt = 1'b1;
        for (int unsigned i = 0; i < SIZE; i++) begin
            pop[i]     = dout_ready[i] & dout_valid[i];
            cnt_nxt[i] = count[i];
            if (push && !pop[i])
                cnt_nxt[i] = count[i] + CW'(1);
            else if (!push && pop[i])
                cnt_nxt[i] = count[i] - CW'(1);
            if (cnt_nxt[i] == FULL)
                rdy_nxt = 1'b0;
        end
    end

    // Control state: counts, pointers and the registered valid/ready outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            dout_valid <= '0;
            din_ready  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                count[i]      <= cnt_nxt[i];
                dout_valid[i] <= (cnt_nxt[i] != '0);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push)
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
            end
            din_ready <= rdy_nxt;
        end
    end

    // FIFO storage; not reset, contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < SIZE; i++)
                mem[i][wr_ptr[i]] <= din_data;
        end
    end

    // Head-of-FIFO read, driven purely by registered pointers and storage.
    always_comb begin
        dout_data = '0;
        for (int unsigned i = 0; i < SIZE; i++)
            dout_data[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i]];
    end

`ifdef BC_DCPL_LEVEL_EN
    // Occupancy export: one registered count per channel.
    always_comb begin
        dout_level = '0;
        for (int unsigned i = 0; i < SIZE; i++)
            dout_level[i*CW +: CW] = count[i];
    end
`endif

endmodule

// File: tb/tb_bc_dcpl.sv
// Testbench for bc_dcpl: per-channel queue model of the broadcast FIFOs,
// compared against the DUT at every falling edge, plus literal checkpoints.
module tb_bc_dcpl;

    localparam int SIZE  = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    din_valid;
    logic [WIDTH-1:0]        din_data;
    logic                    din_ready;
    logic [SIZE-1:0]         dout_valid;
    logic [WIDTH*SIZE-1:0]   dout_data;
    logic [SIZE-1:0]         dout_ready;
`ifdef BC_DCPL_LEVEL_EN
    logic [SIZE*LW-1:0]      dout_level;
`endif

    always #5 clk = ~clk;

    bc_dcpl #(.SIZE(SIZE), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready)
`ifdef BC_DCPL_LEVEL_EN
        ,
        .dout_level (dout_level)
`endif
    );

    // Reference model: one queue per channel, plus expected din_ready.
    logic [WIDTH-1:0] q [SIZE][$];
    bit               exp_rdy  = 1'b0;
    bit               acc_last = 1'b0;
    bit               rnd_data = 1'b0;
    logic [WIDTH-1:0] data_ctr = '0;
    int               tests    = 0;
    int               fails    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules of one rising edge to the model, using the inputs seen there.
    task automatic model_edge();
        bit acc;
        bit room;
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) q[i].delete();
            exp_rdy  = 1'b0;
            acc_last = 1'b0;
        end else begin
            acc = din_valid && exp_rdy;
            for (int i = 0; i < SIZE; i++)
                if (q[i].size() != 0 && dout_ready[i]) void'(q[i].pop_front());
            if (acc)
                for (int i = 0; i < SIZE; i++) q[i].push_back(din_data);
            room = 1'b1;
            for (int i = 0; i < SIZE; i++)
                if (q[i].size() >= DEPTH) room = 1'b0;
            exp_rdy  = room;
            acc_last = acc;
        end
    endtask

    task automatic compare();
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("valid[%0d]", i), 64'(dout_valid[i]), 64'(q[i].size() != 0));
            if (q[i].size() != 0)
                check($sformatf("data[%0d]", i), 64'(dout_data[i*WIDTH +: WIDTH]), 64'(q[i][0]));
`ifdef BC_DCPL_LEVEL_EN
            check($sformatf("level[%0d]", i), 64'(dout_level[i*LW +: LW]), 64'(q[i].size()));
`endif
        end
        check("din_ready", 64'(din_ready), 64'(exp_rdy));
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic cyc(input bit rst, input bit v, input logic [SIZE-1:0] r);
        if (acc_last)
            data_ctr = rnd_data ? WIDTH'($urandom) : data_ctr + WIDTH'(1);
        din_data   = data_ctr;
        rst_n      = ~rst;
        din_valid  = v;
        dout_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = '0;
        @(negedge clk);

        // Reset, then release: din_ready rises one cycle after release.
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        check("rst valid", 64'(dout_valid), 64'h0);
        check("rst ready", 64'(din_ready), 64'h0);
        cyc(0, 0, '1);
        check("release ready", 64'(din_ready), 64'h1);
        check("release valid", 64'(dout_valid), 64'h0);

        // Streaming with all consumers ready: first word visible one cycle after accept.
        data_ctr = 16'h0001;
        cyc(0, 1, '1);
        check("stream first valid", 64'(dout_valid), 64'hF);
        check("stream first data", 64'(dout_data[15:0]), 64'h0001);
        for (int i = 1; i < 16; i++) cyc(0, 1, '1);
        check("stream last data", 64'(dout_data[63:48]), 64'h0010);
        for (int i = 0; i < 3; i++) cyc(0, 0, '1);

        // Channel 1 stalled: input blocks after four accepts.
        data_ctr = 16'h0100;
        for (int i = 0; i < 10; i++) cyc(0, 1, 4'b1101);
        check("stall ready", 64'(din_ready), 64'h0);
        check("stall ch1 head", 64'(dout_data[31:16]), 64'h0100);
        check("stall model ch1 depth", 64'(q[1].size()), 64'd4);
        check("stall ch0 empty", 64'(dout_valid[0]), 64'h0);
        cyc(0, 1, '1);
        check("unstall ready", 64'(din_ready), 64'h1);
        check("unstall ch1 head", 64'(dout_data[31:16]), 64'h0101);
        for (int i = 0; i < 8; i++) cyc(0, 1, '1);
        for (int i = 0; i < 6; i++) cyc(0, 0, '1);

        // Steady push+pop with two words resident: occupancy constant, pointers wrap.
        cyc(0, 1, '0);
        cyc(0, 1, '0);
        for (int i = 0; i < 20; i++) cyc(0, 1, '1);
        check("steady model depth", 64'(q[2].size()), 64'd2);
        check("steady valid", 64'(dout_valid), 64'hF);

        // Mid-operation reset with FIFOs half full.
        cyc(0, 0, '1);
        cyc(0, 0, '1);
        cyc(0, 1, '0);
        cyc(0, 1, '0);
        cyc(1, 0, '0);
        check("midrst valid", 64'(dout_valid), 64'h0);
        check("midrst ready", 64'(din_ready), 64'h0);
        cyc(0, 0, '1);
        check("midrst release ready", 64'(din_ready), 64'h1);
        check("midrst release valid", 64'(dout_valid), 64'h0);

        // Channel 0 held off while three words arrive.
        data_ctr = 16'h0200;
        cyc(0, 1, 4'b1110);
`ifdef BC_DCPL_LEVEL_EN
        check("level ch0 #1", 64'(dout_level[LW-1:0]), 64'd1);
`endif
        cyc(0, 1, 4'b1110);
`ifdef BC_DCPL_LEVEL_EN
        check("level ch0 #2", 64'(dout_level[LW-1:0]), 64'd2);
`endif
        cyc(0, 1, 4'b1110);
`ifdef BC_DCPL_LEVEL_EN
        check("level ch0 #3", 64'(dout_level[LW-1:0]), 64'd3);
`endif
        check("ch0 head after hold", 64'(dout_data[15:0]), 64'h0200);
        for (int i = 0; i < 4; i++) cyc(0, 0, '1);

        // Random valid/ready traffic with random data.
        rnd_data = 1'b1;
        for (int i = 0; i < 10000; i++)
            cyc(0, ($urandom_range(0, 3) != 0), SIZE'($urandom));
        for (int i = 0; i < 8; i++) cyc(0, 0, '1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
